output_bus_receiver: RTL and testbench
======================================

// Module: output_bus_receiver
// PURPOSE
// - Receiving end of the pixel output bus: captures OUTPUT_BUS_WIDTH-pixel words while BUS_VALID is high.
// - Reassembles them into full PIXEL_ARRAY_WIDTH-pixel rows.
// - Presents each row on a valid/ready interface to downstream logic (readout testbench, frame store).
// - Double-buffered: the next row can stream in while the previous row waits for acceptance.
// PARAMETERS
// - PIXEL_ARRAY_WIDTH  8  pixels per row
// - OUTPUT_BUS_WIDTH   2  pixels per bus word; must divide PIXEL_ARRAY_WIDTH; WORDS = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH >= 2
// - PIXEL_BITS         8  bits per pixel
// - COUNT_BITS        16  width of ROW_COUNT
// PORTS
// - CLK          in   1                              system clock, all logic on rising edge
// - RESET        in   1                              synchronous, active-high reset
// - BUS_VALID    in   1                              word present on BUS_DATA this cycle (transmitter sending envelope)
// - BUS_DATA     in   OUTPUT_BUS_WIDTH*PIXEL_BITS    bus word; pixel k of the word at bits [k*PIXEL_BITS +: PIXEL_BITS]
// - ROW_DATA     out  [PIXEL_ARRAY_WIDTH][PIXEL_BITS] assembled row, pixel i at ROW_DATA[i]
// - ROW_VALID    out  1                              ROW_DATA holds an unaccepted row
// - ROW_READY    in   1                              downstream accepts the row when ROW_VALID & ROW_READY
// - ROW_DROPPED  out  1                              1-cycle pulse: a completed row was discarded because the holding register was full
// - BURST_ERROR  out  1                              1-cycle pulse: BUS_VALID fell with a partial row assembled
// - ROW_COUNT    out  COUNT_BITS                     number of rows accepted downstream; wraps mod 2^COUNT_BITS
// BEHAVIOUR
// - Reset (RESET=1 at a rising CLK edge), also mid-row:
//   - All outputs go to 0 and the word index goes to 0.
//   - Assembly and holding registers are cleared; any partial or held row is lost; no pulses are emitted.
// - Word order: the k-th word of a row (k = 0..WORDS-1) fills pixels [k*OUTPUT_BUS_WIDTH +: OUTPUT_BUS_WIDTH].
// - Assembly FSM:
//   - IDLE: index = 0.
//     - BUS_VALID=1: capture word 0 into the assembly register, index <= 1, go to RECV.
//   - RECV, BUS_VALID=1: capture word[index].
//     - index = WORDS-1: the row is complete; index <= 0, go to IDLE.
//     - Back-to-back rows with BUS_VALID held high are legal; the next word starts the next row.
//   - RECV, BUS_VALID=0 with 0 < index < WORDS:
//     - Pulse BURST_ERROR the next cycle.
//     - Discard the partial row, index <= 0, go to IDLE.
// - Row completion:
//   - Completing a row transfers it to the holding register on the same edge that captures the last word.
//   - ROW_VALID=1 from the following cycle, so latency is 1 cycle after the last word.
//   - The transfer is allowed if the holding register is empty, or is being accepted in the same cycle (ROW_VALID & ROW_READY). The simultaneous case leaves ROW_VALID continuously high with new data.
//   - Otherwise the new row is dropped, ROW_DROPPED pulses the next cycle, and the held row is unchanged.
// - Output handshake:
//   - ROW_DATA is stable while ROW_VALID & ~ROW_READY.
//   - On ROW_VALID & ROW_READY: ROW_VALID <= 0 (unless refilled), ROW_COUNT <= ROW_COUNT+1 with wrap.
//   - ROW_READY is ignored while ROW_VALID=0.
// - ROW_DATA keeps its last value after acceptance; it is not cleared.
// - BUS_DATA is sampled only when BUS_VALID=1; X on BUS_DATA while BUS_VALID=0 must not propagate.
// CONFIGURATION
// - ROW_SUM_EN defined:
//   - Adds output ROW_SUM, width PIXEL_BITS+$clog2(PIXEL_ARRAY_WIDTH): the unsigned sum of all pixels of the held row.
//   - It is accumulated word by word during assembly, reset to 0 at each row start, and discarded with dropped or partial rows.
//   - It is transferred with ROW_DATA and is valid under the same ROW_VALID.
// - ROW_SUM_EN undefined: the ROW_SUM port and the accumulator do not exist; all other behaviour is identical.
// TESTING (defaults: WORDS=4, 16-bit words)
// - Single row: BUS_VALID high 4 cycles with words 16'h0100, 16'h0302, 16'h0504, 16'h0706, ROW_READY=1.
//   - Expect ROW_DATA[i]=i for i=0..7.
//   - Expect ROW_VALID high exactly 1 cycle, 1 cycle after the last word; ROW_COUNT=1.
//   - With ROW_SUM_EN: ROW_SUM=28.
// - Back-pressure: ROW_READY=0 and two back-to-back rows (8 words).
//   - Expect row 1 held stable and a ROW_DROPPED pulse after word 8; ROW_COUNT stays 0.
//   - Raise ROW_READY: row 1 is accepted, ROW_COUNT=1.
// - Simultaneous accept and refill: row 2 completes in the cycle row 1 is accepted.
//   - Expect ROW_VALID never low, ROW_DATA switches to row 2, no ROW_DROPPED, ROW_COUNT increments.
// - Short burst: BUS_VALID high 2 cycles, then low.
//   - Expect one BURST_ERROR pulse and no ROW_VALID.
//   - A following full 4-word row is received correctly.
// - Mid-row reset: RESET after word 2 of a row with a held row pending.
//   - Expect all outputs 0 next cycle and no pulses; a subsequent row assembles from word 0.
// - Wrap: force 65536 accepted rows (or COUNT_BITS=4 and 16 rows) -> ROW_COUNT returns to 0.

Source files
------------

// File: rtl/output_bus_receiver.sv
// Reassembles OUTPUT_BUS_WIDTH-pixel bus words into full rows and presents them on a valid/ready port.
// Optional ROW_SUM output (per-row unsigned pixel sum) is enabled by defining ROW_SUM_EN.
module output_bus_receiver #(
    parameter int PIXEL_ARRAY_WIDTH = 8,
    parameter int OUTPUT_BUS_WIDTH  = 2,
    parameter int PIXEL_BITS        = 8,
    parameter int COUNT_BITS        = 16
) (
    input  logic                                            CLK,
    input  logic                                            RESET,
    input  logic                                            BUS_VALID,
    input  logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]          BUS_DATA,
    output logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]    ROW_DATA,
    output logic                                            ROW_VALID,
    input  logic                                            ROW_READY,
    output logic                                            ROW_DROPPED,
    output logic                                            BURST_ERROR,
    output logic [COUNT_BITS-1:0]                           ROW_COUNT
`ifdef ROW_SUM_EN
    ,
    output logic [PIXEL_BITS+$clog2(PIXEL_ARRAY_WIDTH)-1:0] ROW_SUM
`endif
);
    localparam int WORDS = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t                                         state;
    logic [IDX_W-1:0]                               idx;
    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]   asm_row;
    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]   row_next;
    logic                                           row_done;
    logic                                           accept;
    logic                                           load;

    // Splice the current bus word into its slot; BUS_DATA is only selected while BUS_VALID is high.
    for (genvar w = 0; w < WORDS; w++) begin : g_word
        for (genvar p = 0; p < OUTPUT_BUS_WIDTH; p++) begin : g_px
            assign row_next[w*OUTPUT_BUS_WIDTH+p] = (BUS_VALID && idx == IDX_W'(w))
                ? BUS_DATA[p*PIXEL_BITS +: PIXEL_BITS]
                : asm_row[w*OUTPUT_BUS_WIDTH+p];
        end
    end

    assign row_done = (state == RECV) && BUS_VALID && (idx == LAST);
    assign accept   = ROW_VALID && ROW_READY;
    assign load     = row_done && (!ROW_VALID || ROW_READY);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            idx         <= '0;
            asm_row     <= '0;
            ROW_DATA    <= '0;
            ROW_VALID   <= 1'b0;
            ROW_DROPPED <= 1'b0;
            BURST_ERROR <= 1'b0;
            ROW_COUNT   <= '0;
        end else begin
            ROW_DROPPED <= row_done && !load;
            BURST_ERROR <= (state == RECV) && !BUS_VALID;
            if (BUS_VALID)
                asm_row <= row_next;
            case (state)
                IDLE: if (BUS_VALID) begin
                    idx   <= IDX_W'(1);
                    state <= RECV;
                end
                RECV: if (BUS_VALID && idx != LAST) begin
                    idx <= idx + IDX_W'(1);
                end else begin
                    idx   <= '0;
                    state <= IDLE;
                end
                default: begin
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
            // A refill in the accepting cycle keeps ROW_VALID high without a bubble.
            if (load) begin
                ROW_DATA  <= row_next;
                ROW_VALID <= 1'b1;
            end else if (accept) begin
                ROW_VALID <= 1'b0;
            end
            if (accept)
                ROW_COUNT <= ROW_COUNT + 1'b1;
        end
    end

`ifdef ROW_SUM_EN
    localparam int SUM_W = PIXEL_BITS + $clog2(PIXEL_ARRAY_WIDTH);
    logic [SUM_W-1:0] word_sum;
    logic [SUM_W-1:0] acc;

    always_comb begin
        word_sum = '0;
        for (int p = 0; p < OUTPUT_BUS_WIDTH; p++)
            word_sum = word_sum + SUM_W'(BUS_DATA[p*PIXEL_BITS +: PIXEL_BITS]);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc     <= '0;
            ROW_SUM <= '0;
        end else begin
            if (BUS_VALID)
                acc <= (state == IDLE) ? word_sum : acc + word_sum;
            if (load)
                ROW_SUM <= acc + word_sum;
        end
    end
`endif
endmodule

// File: tb/tb_output_bus_receiver.sv
// Self-checking bench for output_bus_receiver: directed scenarios plus randomized traffic against a queue-based row model.
module tb_output_bus_receiver;
    localparam int PAW   = 8;
    localparam int OBW   = 2;
    localparam int PB    = 8;
    localparam int CB    = 4;
    localparam int WORDS = PAW / OBW;
    localparam int BW    = OBW * PB;

    logic                     CLK = 1'b0;
    logic                     RESET = 1'b1;
    logic                     BUS_VALID = 1'b0;
    logic [BW-1:0]            BUS_DATA = '0;
    logic                     ROW_READY = 1'b0;
    logic [PAW-1:0][PB-1:0]   ROW_DATA;
    logic                     ROW_VALID;
    logic                     ROW_DROPPED;
    logic                     BURST_ERROR;
    logic [CB-1:0]            ROW_COUNT;
`ifdef ROW_SUM_EN
    localparam int SW = PB + $clog2(PAW);
    logic [SW-1:0]            ROW_SUM;
    logic [SW-1:0]            m_sum = '0;
`endif

    always #5 CLK = ~CLK;

    output_bus_receiver #(
        .PIXEL_ARRAY_WIDTH(PAW), .OUTPUT_BUS_WIDTH(OBW), .PIXEL_BITS(PB), .COUNT_BITS(CB)
    ) dut (
        .CLK(CLK), .RESET(RESET), .BUS_VALID(BUS_VALID), .BUS_DATA(BUS_DATA),
        .ROW_DATA(ROW_DATA), .ROW_VALID(ROW_VALID), .ROW_READY(ROW_READY),
        .ROW_DROPPED(ROW_DROPPED), .BURST_ERROR(BURST_ERROR), .ROW_COUNT(ROW_COUNT)
`ifdef ROW_SUM_EN
        , .ROW_SUM(ROW_SUM)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pixels of the row in flight, plus the row waiting downstream.
    logic [PB-1:0]          cur[$];
    logic [PAW-1:0][PB-1:0] m_row = '0;
    bit                     m_valid = 0;
    bit                     m_drop = 0;
    bit                     m_berr = 0;
    logic [CB-1:0]          m_count = '0;

    function automatic logic [BW-1:0] rnd();
        return BW'($urandom);
    endfunction

    // Drive one cycle, advance the model over the edge, then settle for sampling.
    task automatic cyc(input logic bv, input logic [BW-1:0] d, input logic rdy, input logic rst);
        bit acc;
        bit loaded;
        int s;
        BUS_VALID = bv;
        BUS_DATA  = d;
        ROW_READY = rdy;
        RESET     = rst;
        @(posedge CLK);
        acc    = m_valid && rdy;
        loaded = 0;
        m_drop = 0;
        m_berr = 0;
        if (rst) begin
            cur.delete();
            m_row   = '0;
            m_valid = 0;
            m_count = '0;
`ifdef ROW_SUM_EN
            m_sum   = '0;
`endif
        end else begin
            if (bv) begin
                for (int p = 0; p < OBW; p++) cur.push_back(d[p*PB +: PB]);
                if (cur.size() == PAW) begin
                    if (!m_valid || rdy) begin
                        s = 0;
                        for (int i = 0; i < PAW; i++) begin
                            m_row[i] = cur[i];
                            s += int'(cur[i]);
                        end
`ifdef ROW_SUM_EN
                        m_sum = SW'(s);
`endif
                        loaded = 1;
                    end else begin
                        m_drop = 1;
                    end
                    cur.delete();
                end
            end else if (cur.size() != 0) begin
                m_berr = 1;
                cur.delete();
            end
            if (acc) begin
                m_count++;
                if (!loaded) m_valid = 0;
            end
            if (loaded) m_valid = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, rnd(), 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks += 5;
        if (ROW_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ROW_VALID); end
        if (ROW_DATA !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", ROW_DATA); end
        if (ROW_COUNT !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ROW_COUNT); end
        if (ROW_DROPPED !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", ROW_DROPPED); end
        if (BURST_ERROR !== 1'b0) begin errors++; $display("FAIL reset_berr: got %b expected 0", BURST_ERROR); end
    endtask

    task automatic test_single_row();
        logic [BW-1:0] w[WORDS] = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        logic [PAW-1:0][PB-1:0] exp_row;
        for (int i = 0; i < PAW; i++) exp_row[i] = PB'(i);
        for (int k = 0; k < WORDS; k++) begin
            cyc(1'b1, w[k], 1'b1, 1'b0);
            if (k < WORDS - 1) begin
                checks++;
                if (ROW_VALID !== 1'b0) begin errors++; $display("FAIL single_early_valid word %0d: got %b expected 0", k, ROW_VALID); end
            end
        end
        checks += 3;
        if (ROW_VALID !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", ROW_VALID); end
        if (ROW_DATA !== exp_row) begin errors++; $display("FAIL single_data: got %h expected %h", ROW_DATA, exp_row); end
        if (ROW_COUNT !== 4'd0) begin errors++; $display("FAIL single_count_pre: got %0d expected 0", ROW_COUNT); end
`ifdef ROW_SUM_EN
        checks++;
        if (ROW_SUM !== SW'(28)) begin errors++; $display("FAIL single_sum: got %0d expected 28", ROW_SUM); end
`endif
        cyc(1'b0, 'x, 1'b1, 1'b0);
        checks += 3;
        if (ROW_VALID !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b expected 0", ROW_VALID); end
        if (ROW_COUNT !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", ROW_COUNT); end
        if (ROW_DATA !== exp_row) begin errors++; $display("FAIL single_data_kept: got %h expected %h", ROW_DATA, exp_row); end
    endtask

    task automatic test_backpressure();
        logic [WORDS-1:0][BW-1:0] r1, r2;
        for (int k = 0; k < WORDS; k++) begin r1[k] = rnd(); r2[k] = rnd(); end
        for (int k = 0; k < WORDS; k++) cyc(1'b1, r1[k], 1'b0, 1'b0);
        // Word k of a row occupies the same bit range as pixels [k*OBW +: OBW] of ROW_DATA.
        checks += 2;
        if (ROW_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", ROW_VALID); end
        if (ROW_DATA !== r1) begin errors++; $display("FAIL bp_row1: got %h expected %h", ROW_DATA, r1); end
        for (int k = 0; k < WORDS; k++) begin
            cyc(1'b1, r2[k], 1'b0, 1'b0);
            checks += 2;
            if (ROW_DATA !== r1) begin errors++; $display("FAIL bp_hold word %0d: got %h expected %h", k, ROW_DATA, r1); end
            if (ROW_DROPPED !== (k == WORDS - 1)) begin errors++; $display("FAIL bp_drop word %0d: got %b expected %b", k, ROW_DROPPED, k == WORDS - 1); end
        end
        checks++;
        if (ROW_COUNT !== 4'd1) begin errors++; $display("FAIL bp_count_hold: got %0d expected 1", ROW_COUNT); end
        cyc(1'b0, 'x, 1'b0, 1'b0);
        checks += 2;
        if (ROW_DROPPED !== 1'b0) begin errors++; $display("FAIL bp_drop_pulse: got %b expected 0", ROW_DROPPED); end
        if (ROW_VALID !== 1'b1) begin errors++; $display("FAIL bp_still_valid: got %b expected 1", ROW_VALID); end
        cyc(1'b0, 'x, 1'b1, 1'b0);
        checks += 2;
        if (ROW_VALID !== 1'b0) begin errors++; $display("FAIL bp_accept_valid: got %b expected 0", ROW_VALID); end
        if (ROW_COUNT !== 4'd2) begin errors++; $display("FAIL bp_accept_count: got %0d expected 2", ROW_COUNT); end
    endtask

    task automatic test_simultaneous();
        logic [WORDS-1:0][BW-1:0] r1, r2;
        for (int k = 0; k < WORDS; k++) begin r1[k] = rnd(); r2[k] = rnd(); end
        for (int k = 0; k < 2 * WORDS; k++) begin
            cyc(1'b1, (k < WORDS) ? r1[k] : r2[k-WORDS], k == 2 * WORDS - 1, 1'b0);
            checks++;
            if (ROW_DROPPED !== 1'b0) begin errors++; $display("FAIL sim_drop word %0d: got %b expected 0", k, ROW_DROPPED); end
            if (k >= WORDS - 1) begin
                checks++;
                if (ROW_VALID !== 1'b1) begin errors++; $display("FAIL sim_valid word %0d: got %b expected 1", k, ROW_VALID); end
            end
        end
        checks += 2;
        if (ROW_DATA !== r2) begin errors++; $display("FAIL sim_row2: got %h expected %h", ROW_DATA, r2); end
        if (ROW_COUNT !== 4'd3) begin errors++; $display("FAIL sim_count: got %0d expected 3", ROW_COUNT); end
        cyc(1'b0, 'x, 1'b1, 1'b0);
        checks += 2;
        if (ROW_VALID !== 1'b0) begin errors++; $display("FAIL sim_final_valid: got %b expected 0", ROW_VALID); end
        if (ROW_COUNT !== 4'd4) begin errors++; $display("FAIL sim_final_count: got %0d expected 4", ROW_COUNT); end
    endtask

    task automatic test_short_burst();
        logic [WORDS-1:0][BW-1:0] r;
        for (int k = 0; k < WORDS; k++) r[k] = rnd();
        cyc(1'b1, rnd(), 1'b1, 1'b0);
        cyc(1'b1, rnd(), 1'b1, 1'b0);
        cyc(1'b0, 'x, 1'b1, 1'b0);
        checks += 2;
        if (BURST_ERROR !== 1'b1) begin errors++; $display("FAIL burst_pulse: got %b expected 1", BURST_ERROR); end
        if (ROW_VALID !== 1'b0) begin errors++; $display("FAIL burst_valid: got %b expected 0", ROW_VALID); end
        cyc(1'b0, 'x, 1'b1, 1'b0);
        checks++;
        if (BURST_ERROR !== 1'b0) begin errors++; $display("FAIL burst_one_cycle: got %b expected 0", BURST_ERROR); end
        for (int k = 0; k < WORDS; k++) cyc(1'b1, r[k], 1'b0, 1'b0);
        checks += 3;
        if (ROW_VALID !== 1'b1) begin errors++; $display("FAIL burst_next_valid: got %b expected 1", ROW_VALID); end
        if (ROW_DATA !== r) begin errors++; $display("FAIL burst_next_data: got %h expected %h", ROW_DATA, r); end
        if (BURST_ERROR !== 1'b0) begin errors++; $display("FAIL burst_next_berr: got %b expected 0", BURST_ERROR); end
        cyc(1'b0, 'x, 1'b1, 1'b0);
        checks++;
        if (ROW_COUNT !== 4'd5) begin errors++; $display("FAIL burst_count: got %0d expected 5", ROW_COUNT); end
    endtask

    task automatic test_mid_reset();
        logic [WORDS-1:0][BW-1:0] r;
        for (int k = 0; k < WORDS; k++) cyc(1'b1, rnd(), 1'b0, 1'b0);
        cyc(1'b1, rnd(), 1'b0, 1'b0);
        cyc(1'b1, rnd(), 1'b0, 1'b0);
        cyc(1'b1, rnd(), 1'b1, 1'b1);
        checks += 5;
        if (ROW_VALID !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", ROW_VALID); end
        if (ROW_DATA !== '0) begin errors++; $display("FAIL mrst_data: got %h expected 0", ROW_DATA); end
        if (ROW_COUNT !== '0) begin errors++; $display("FAIL mrst_count: got %0d expected 0", ROW_COUNT); end
        if (ROW_DROPPED !== 1'b0) begin errors++; $display("FAIL mrst_drop: got %b expected 0", ROW_DROPPED); end
        if (BURST_ERROR !== 1'b0) begin errors++; $display("FAIL mrst_berr: got %b expected 0", BURST_ERROR); end
        cyc(1'b0, 'x, 1'b0, 1'b0);
        checks++;
        if (BURST_ERROR !== 1'b0) begin errors++; $display("FAIL mrst_no_pulse: got %b expected 0", BURST_ERROR); end
        for (int k = 0; k < WORDS; k++) r[k] = rnd();
        for (int k = 0; k < WORDS; k++) cyc(1'b1, r[k], 1'b0, 1'b0);
        checks += 2;
        if (ROW_VALID !== 1'b1) begin errors++; $display("FAIL mrst_row_valid: got %b expected 1", ROW_VALID); end
        if (ROW_DATA !== r) begin errors++; $display("FAIL mrst_row_data: got %h expected %h", ROW_DATA, r); end
    endtask

    task automatic test_random();
        logic bv;
        for (int i = 0; i < 600; i++) begin
            bv = $urandom_range(0, 9) < 7;
            cyc(bv, bv ? rnd() : 'x, 1'($urandom_range(0, 1)), $urandom_range(0, 149) == 0);
            checks += 5;
            if (ROW_VALID !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", i, ROW_VALID, m_valid); end
            if (ROW_DATA !== m_row) begin errors++; $display("FAIL rnd_data cyc %0d: got %h expected %h", i, ROW_DATA, m_row); end
            if (ROW_DROPPED !== m_drop) begin errors++; $display("FAIL rnd_drop cyc %0d: got %b expected %b", i, ROW_DROPPED, m_drop); end
            if (BURST_ERROR !== m_berr) begin errors++; $display("FAIL rnd_berr cyc %0d: got %b expected %b", i, BURST_ERROR, m_berr); end
            if (ROW_COUNT !== m_count) begin errors++; $display("FAIL rnd_count cyc %0d: got %0d expected %0d", i, ROW_COUNT, m_count); end
`ifdef ROW_SUM_EN
            checks++;
            if (ROW_SUM !== m_sum) begin errors++; $display("FAIL rnd_sum cyc %0d: got %0d expected %0d", i, ROW_SUM, m_sum); end
`endif
        end
    endtask

    task automatic test_wrap();
        cyc(1'b0, 'x, 1'b0, 1'b1);
        for (int r = 0; r < (1 << CB); r++) begin
            for (int k = 0; k < WORDS; k++) cyc(1'b1, rnd(), 1'b1, 1'b0);
            checks++;
            if (ROW_COUNT !== CB'(r)) begin errors++; $display("FAIL wrap_step row %0d: got %0d expected %0d", r, ROW_COUNT, r); end
        end
        cyc(1'b0, 'x, 1'b1, 1'b0);
        checks += 3;
        if (ROW_COUNT !== '0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", ROW_COUNT); end
        if (ROW_COUNT !== m_count) begin errors++; $display("FAIL wrap_model: got %0d expected %0d", ROW_COUNT, m_count); end
        if (ROW_VALID !== 1'b0) begin errors++; $display("FAIL wrap_valid: got %b expected 0", ROW_VALID); end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_simultaneous();
        test_short_burst();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
